sevenseg_scan_ctrl: RTL

//  Time-multiplexed driver for the Nexys A7 8-digit seven-segment display (AN, CA..CG, DP).

---
 rtl/sevenseg_scan_ctrl_if.sv | 46 ++++
 rtl/sevenseg_scan_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Register-side and pad-side bundle for the 8-digit seven-segment scanner.
// The master is the SoC register block; the slave is the scan controller.
interface sevenseg_scan_ctrl_if;
   logic        i_value_we;
   logic [31:0] i_value;
   logic        i_mask_we;
   logic [7:0]  i_mask;
   logic [7:0]  i_dp;
   logic        i_enable;
   logic        i_lzb;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp_n;
   logic        o_frame_tick;
   logic        o_pending;

   modport master (
      output i_value_we,
      output i_value,
      output i_mask_we,
      output i_mask,
      output i_dp,
      output i_enable,
      output i_lzb,
      input  o_an,
      input  o_seg,
      input  o_dp_n,
      input  o_frame_tick,
      input  o_pending
   );

   modport slave (
      input  i_value_we,
      input  i_value,
      input  i_mask_we,
      input  i_mask,
      input  i_dp,
      input  i_enable,
      input  i_lzb,
      output o_an,
      output o_seg,
      output o_dp_n,
      output o_frame_tick,
      output o_pending
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment driver, active-low pads,
// dead-time between digits and frame-boundary commit of buffered writes.
module sevenseg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 12500,
   parameter int unsigned DEAD_CYC    = 64
) (
   input logic                 clk,
   input logic                 rstn,
   sevenseg_scan_ctrl_if.slave bus
);

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } state_t;

   localparam logic [15:0] LP_SHOW_LAST = 16'(REFRESH_DIV - 1);
   localparam logic [15:0] LP_DEAD_LAST = 16'(DEAD_CYC - 1);

   state_t      r_state;
   logic [2:0]  r_idx;
   logic [15:0] r_cnt;

   logic [31:0] r_pend_val;
   logic [7:0]  r_pend_mask;
   logic [7:0]  r_pend_dp;
   logic [31:0] r_act_val;
   logic [7:0]  r_act_mask;
   logic [7:0]  r_act_dp;

   logic [7:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp_n;
   logic        r_tick;
   logic        r_pending;

   state_t      w_nstate;
   logic [2:0]  w_nidx;
   logic [15:0] w_ncnt;
   logic        w_commit;
   logic [7:0]  w_hz;
   logic        w_lzb_blank;
   logic        w_lit;
   logic [3:0]  w_nib;

   function automatic logic [6:0] f_hex(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h7F;
      unique case (d)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   always_comb begin
      w_nstate = r_state;
      w_nidx   = r_idx;
      w_ncnt   = r_cnt + 16'd1;
      w_commit = 1'b0;
      unique case (r_state)
         ST_BLANK: begin
            if (r_cnt == LP_DEAD_LAST) begin
               w_nstate = ST_SHOW;
               w_ncnt   = '0;
            end
         end
         ST_SHOW: begin
            if (r_cnt == LP_SHOW_LAST) begin
               w_nstate = ST_BLANK;
               w_ncnt   = '0;
               w_nidx   = r_idx + 3'd1;
               w_commit = (r_idx == 3'd7);
            end
         end
      endcase
   end

   // w_hz[i]: every nibble from digit i upward is zero
   always_comb begin
      w_hz = '0;
      for (int i = 0; i < 8; i++) begin
         w_hz[i] = ((r_act_val >> (4 * i)) == 32'd0);
      end
   end

   // Outputs are computed for the state being entered so they line up with it
   always_comb begin
      w_nib       = r_act_val[{w_nidx, 2'b00} +: 4];
      w_lzb_blank = bus.i_lzb & (w_nidx != 3'd0) & w_hz[w_nidx];
      w_lit       = (w_nstate == ST_SHOW) & bus.i_enable
                  & r_act_mask[w_nidx] & ~w_lzb_blank;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= ST_BLANK;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_pend_val  <= '0;
         r_pend_mask <= '0;
         r_pend_dp   <= '0;
         r_act_val   <= '0;
         r_act_mask  <= '0;
         r_act_dp    <= '0;
         r_an        <= 8'hFF;
         r_seg       <= 7'h7F;
         r_dp_n      <= 1'b1;
         r_tick      <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_idx   <= w_nidx;
         r_cnt   <= w_ncnt;
         r_tick  <= w_commit;
         if (w_commit) begin
            r_act_val  <= r_pend_val;
            r_act_mask <= r_pend_mask;
            r_act_dp   <= r_pend_dp;
         end
         if (bus.i_value_we) begin
            r_pend_val <= bus.i_value;
         end
         if (bus.i_mask_we) begin
            r_pend_mask <= bus.i_mask;
            r_pend_dp   <= bus.i_dp;
         end
         // A write landing on the commit edge keeps the flag set
         r_pending <= (r_pending & ~w_commit)
                    | bus.i_value_we | bus.i_mask_we;
         if (w_lit) begin
            r_an   <= ~(8'b1 << w_nidx);
            r_seg  <= f_hex(w_nib);
            r_dp_n <= ~r_act_dp[w_nidx];
         end else begin
            r_an   <= 8'hFF;
            r_seg  <= 7'h7F;
            r_dp_n <= 1'b1;
         end
      end
   end

   assign bus.o_an         = r_an;
   assign bus.o_seg        = r_seg;
   assign bus.o_dp_n       = r_dp_n;
   assign bus.o_frame_tick = r_tick;
   assign bus.o_pending    = r_pending;

endmodule
